bank_mapper: RTL and testbench
==============================

Name: bank_mapper

Overview:
- Parametrised successor of the single-register MX page logic.
- Holds one page register per address window and decodes writes to a 4-byte page-select port. Runs a boot-shadow state machine that keeps ROM mapped until the CPU first touches the upper half of memory.
- Produces the physical SDRAM address {page, addr} for the sram mux.
- Sits between the k580vm80a bus and the sram address mux. Replaces the fixed page logic and extends it to multiple windows, bounded page counts and a host-load mode.

Parameters:
- ADDR_W, 16, CPU address width.
- PAGE_W, 4, page register width; phys address width is PAGE_W+ADDR_W.
- WIN_W, 1, log2 of window count. Window = addr[ADDR_W-1 -: WIN_W]. WIN_W=0 means a single window. PAGE_W+WIN_W<=8.
- NUM_PAGES, 10, number of legal pages (0..NUM_PAGES-1).
- ROM_PAGE, 1, page holding monitor ROM.
- RAMDISK_BASE, 2, first ramdisk page; offset-1 writes map to RAMDISK_BASE+data.
- SEL_BASE, 16'hFFFC, page-select port base; must be 4-aligned.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  CPU address bus.
- din  in  8  CPU data out.
- wr_n  in  1  CPU write strobe, active low.
- rd  in  1  CPU DBIN.
- en  in  1  mapper enable (MX with disk); when 0, select-port writes are ignored.
- shadow_en  in  1  enables boot-shadow exit on an upper-half access.
- load  in  1  host download active (rks_load).
- phys_addr  out  PAGE_W+ADDR_W  {page of addressed window, addr}; combinational from addr.
- page_o  out  PAGE_W  page of addressed window.
- rom_active  out  1  page_o==ROM_PAGE.
- sel_hit  out  1  addr in SEL_BASE..SEL_BASE+3; combinational.
- err  out  1  sticky illegal-page flag.
- dout  out  8  readback data.
- state_o  out  2  FSM state.

Behaviour:
- Reset (reset_n=0, async):
  - all pages=ROM_PAGE, state=BOOT, err=0, internal old_wr=1.
  - Outputs at reset: dout=8'hFF, state_o=BOOT. phys_addr, page_o and rom_active derive from the ROM_PAGE registers.
- Write edge: wr_edge = old_wr & ~wr_n, evaluated each clk_sys; old_wr <= wr_n.
- Register updates land on the clk_sys edge after wr_edge is detected. phys_addr reflects the new page from the following cycle.
- Select port: on wr_edge & sel_hit & en & state!=LOAD, with w = din[7 -: WIN_W] (w=0 when WIN_W=0):
  - offset 0: page[w] <= 0.
  - offset 1: p = RAMDISK_BASE + din[PAGE_W-1:0], computed PAGE_W+1 bits wide. If p < NUM_PAGES, page[w] <= p. Otherwise page[w] is unchanged and err <= 1.
  - offset 2 or 3: page[w] <= ROM_PAGE.
- FSM:
  - BOOT: all windows read ROM_PAGE. Exit to RUN when shadow_en and (rd | wr_edge) and addr[ADDR_W-1]=1; all pages <= 0 on the same edge. If shadow_en=0, BOOT exits on the first select-port write only.
  - RUN: normal operation.
  - LOAD: entered from any state when load=1. All pages forced to 0 every cycle; select writes ignored.
  - LOAD exits to RUN on the first cycle with load=0.
- Priority, highest first: reset_n, load, boot exit, select write.
- A boot exit and a select write in the same cycle: pages cleared, then the written window takes the written value.
- err clears only on reset.
- Offset-1 data that wraps a PAGE_W bit field is caught by the PAGE_W+1-bit compare and never wraps silently.

Optional Feature:
- BANK_MAPPER_READBACK_EN.
- Defined: when rd & sel_hit, dout is registered one cycle later as {err, zero pad, page[addr[1:0] mod 2^WIN_W]}. Page is in the low PAGE_W bits, err in bit 7.
- Undefined: dout is constant 8'hFF and the readback logic is not built.

Decomposition:
- Package bank_mapper_pkg:
  - state enum {BOOT, RUN, LOAD};
  - offset constants OFS_RAM=0, OFS_DISK=1, OFS_ROM=2.
- Sub-module bank_mapper_win:
  - one page register with its async reset value, clear, force and load-value inputs;
  - instantiated 2^WIN_W times in a generate loop.
- The top holds the FSM, edge detect and decode.

Test Plan:
- Reset release, rd at addr 0x0100 → phys_addr=0x10100, rom_active=1, state_o=BOOT.
- shadow_en=1, rd at 0x8000 → next cycle all pages 0, phys_addr for 0x8000 = 0x08000, state RUN.
- RUN, en=1, write din=0x03 to 0xFFFD (WIN_W=1, window 0) → page[0]=5; addr 0x1234 gives phys 0x51234. Window 1 is unchanged.
- Write din=0x0F to 0xFFFD → page unchanged, err=1 and stays 1 through later legal writes.
- load=1 during RUN with page[0]=5 → page 0 next cycle; a write to 0xFFFE is ignored. load=0 → RUN, and a 0xFFFE write then sets ROM_PAGE.
- reset_n pulse mid-write (wr_n low) → immediate ROM_PAGE/BOOT; no write edge is taken on release while wr_n is still low.

Source files
------------

// File: rtl/bank_mapper_pkg.sv
// Shared types and select-port offsets for the bank mapper.
package bank_mapper_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [1:0] OFS_RAM  = 2'd0;
  localparam logic [1:0] OFS_DISK = 2'd1;
  localparam logic [1:0] OFS_ROM  = 2'd2;

endpackage

// File: rtl/bank_mapper_win.sv
// One window page register: load-mode force, select-port load, boot-exit clear.
module bank_mapper_win #(
  parameter int                PAGE_W  = 4,
  parameter logic [PAGE_W-1:0] RST_VAL = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              force_clr,
  input  logic              clr,
  input  logic              ld,
  input  logic [PAGE_W-1:0] ld_val,
  output logic [PAGE_W-1:0] page
);

  // A select write on the boot-exit edge wins over the clear, so ld sits above clr.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       page <= RST_VAL;
    else if (force_clr) page <= '0;
    else if (ld)        page <= ld_val;
    else if (clr)       page <= '0;
  end

endmodule

// File: rtl/bank_mapper.sv
// Multi-window page mapper with boot shadow and host-load mode.
// Optional readback port: define BANK_MAPPER_READBACK_EN.
module bank_mapper
  import bank_mapper_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int PAGE_W       = 4,
  parameter int WIN_W        = 1,
  parameter int NUM_PAGES    = 10,
  parameter int ROM_PAGE     = 1,
  parameter int RAMDISK_BASE = 2,
  parameter int SEL_BASE     = 'hFFFC
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               din,
  input  logic                     wr_n,
  input  logic                     rd,
  input  logic                     en,
  input  logic                     shadow_en,
  input  logic                     load,
  output logic [PAGE_W+ADDR_W-1:0] phys_addr,
  output logic [PAGE_W-1:0]        page_o,
  output logic                     rom_active,
  output logic                     sel_hit,
  output logic                     err,
  output logic [7:0]               dout,
  output logic [1:0]               state_o
);

  localparam int                IDX_W  = (WIN_W > 0) ? WIN_W : 1;
  localparam int                NWIN   = 1 << WIN_W;
  localparam int                NSLOT  = 1 << IDX_W;
  localparam logic [PAGE_W-1:0] ROM_P  = ROM_PAGE[PAGE_W-1:0];
  localparam logic [PAGE_W-1:0] DISK_P = RAMDISK_BASE[PAGE_W-1:0];
  localparam logic [PAGE_W:0]   NUM_P  = NUM_PAGES[PAGE_W:0];
  localparam logic [ADDR_W-1:0] SEL_A  = SEL_BASE[ADDR_W-1:0];

  state_t            state, state_n;
  logic              old_wr, armed, wr_edge, sel_wr, boot_exit, bad;
  logic [IDX_W-1:0]  win, wsel;
  logic [PAGE_W:0]   disk_p;
  logic [PAGE_W-1:0] ld_val;
  logic [NSLOT-1:0]  ld_vec;
  logic [PAGE_W-1:0] pages [NSLOT];
  logic              unused_din;

  if (WIN_W > 0) begin : g_idx
    assign win  = addr[ADDR_W-1 -: IDX_W];
    assign wsel = din[7 -: IDX_W];
  end else begin : g_noidx
    assign win  = '0;
    assign wsel = '0;
  end

  assign unused_din = ^din;
  assign sel_hit    = (addr[ADDR_W-1:2] == SEL_A[ADDR_W-1:2]);
  assign page_o     = pages[win];
  assign phys_addr  = {page_o, addr};
  assign rom_active = (page_o == ROM_P);
  assign state_o    = state;

  // armed keeps a write that straddles reset release from counting as a fresh edge.
  assign wr_edge   = armed & old_wr & ~wr_n;
  assign sel_wr    = wr_edge & sel_hit & en & ~load & (state != LOAD);
  assign boot_exit = (state == BOOT) & ~load &
                     ((shadow_en & (rd | wr_edge) & addr[ADDR_W-1]) | sel_wr);
  assign disk_p    = {1'b0, DISK_P} + {1'b0, din[PAGE_W-1:0]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ld_val = '0;
    bad    = 1'b0;
    ld_vec = '0;
    case (addr[1:0])
      OFS_RAM:  ld_val = '0;
      OFS_DISK: begin
        ld_val = disk_p[PAGE_W-1:0];
        bad    = (disk_p >= NUM_P);
      end
      default:  ld_val = ROM_P;
    endcase
    if (sel_wr && !bad) ld_vec[wsel] = 1'b1;
  end

  always_comb begin
    state_n = state;
    if (load) state_n = LOAD;
    else begin
      case (state)
        BOOT:    if (boot_exit) state_n = RUN;
        LOAD:    state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BOOT;
      old_wr <= 1'b1;
      armed  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      old_wr <= wr_n;
      armed  <= 1'b1;
      err    <= err | (sel_wr & bad);
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_win
    if (i < NWIN) begin : g_reg
      bank_mapper_win #(.PAGE_W(PAGE_W), .RST_VAL(ROM_P)) u_win (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .force_clr (load),
        .clr       (boot_exit),
        .ld        (ld_vec[i]),
        .ld_val    (ld_val),
        .page      (pages[i])
      );
    end else begin : g_tie
      assign pages[i] = '0;
    end
  end

`ifdef BANK_MAPPER_READBACK_EN
  logic [IDX_W-1:0] rb_idx;
  logic [7:0]       rb;

  assign rb_idx = IDX_W'(addr[1:0]) & IDX_W'(NWIN - 1);

  always_comb begin
    rb              = '0;
    rb[PAGE_W-1:0]  = pages[rb_idx];
    rb[7]           = err;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          dout <= 8'hFF;
    else if (rd & sel_hit) dout <= rb;
  end
`else
  assign dout = 8'hFF;
`endif

endmodule

// File: tb/tb_bank_mapper.sv
// Directed bench for bank_mapper with default parameters (two windows).
module tb_bank_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr_n, rd, en, shadow_en, load;
  logic [19:0] phys_addr;
  logic [3:0]  page_o;
  logic        rom_active, sel_hit, err;
  logic [7:0]  dout;
  logic [1:0]  state_o;

  int vectors = 0;
  int miscompares = 0;

  bank_mapper dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .addr       (addr),
    .din        (din),
    .wr_n       (wr_n),
    .rd         (rd),
    .en         (en),
    .shadow_en  (shadow_en),
    .load       (load),
    .phys_addr  (phys_addr),
    .page_o     (page_o),
    .rom_active (rom_active),
    .sel_hit    (sel_hit),
    .err        (err),
    .dout       (dout),
    .state_o    (state_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    tick();
  endtask

  task automatic peek(input logic [15:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; addr = 16'h0100; din = 8'h00; wr_n = 1'b1;
    rd = 1'b0; en = 1'b1; shadow_en = 1'b1; load = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    vectors++; if (phys_addr !== 20'h10100) begin miscompares++; $display("FAIL reset_phys got %h want %h", phys_addr, 20'h10100); end
    vectors++; if (rom_active !== 1'b1) begin miscompares++; $display("FAIL reset_rom got %b want 1", rom_active); end
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state_o); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (dout !== 8'hFF) begin miscompares++; $display("FAIL reset_dout got %h want ff", dout); end
    rd = 1'b1; tick(); rd = 1'b0;
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL low_rd_stays_boot got %0d want 0", state_o); end
  endtask

  task automatic test_shadow_exit();
    addr = 16'h8000; rd = 1'b1; tick(); rd = 1'b0;
    vectors++; if (phys_addr !== 20'h08000) begin miscompares++; $display("FAIL exit_phys got %h want %h", phys_addr, 20'h08000); end
    vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL exit_state got %0d want 1", state_o); end
    peek(16'h0100);
    vectors++; if (phys_addr !== 20'h00100) begin miscompares++; $display("FAIL exit_win0 got %h want %h", phys_addr, 20'h00100); end
    vectors++; if (rom_active !== 1'b0) begin miscompares++; $display("FAIL exit_rom got %b want 0", rom_active); end
  endtask

  task automatic test_disk_write();
    cpu_write(16'hFFFD, 8'h03);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h51234) begin miscompares++; $display("FAIL disk_win0 got %h want %h", phys_addr, 20'h51234); end
    peek(16'h9234);
    vectors++; if (phys_addr !== 20'h09234) begin miscompares++; $display("FAIL disk_win1 got %h want %h", phys_addr, 20'h09234); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL disk_err got %b want 0", err); end
    peek(16'hFFFB);
    vectors++; if (sel_hit !== 1'b0) begin miscompares++; $display("FAIL hit_below got %b want 0", sel_hit); end
    peek(16'hFFFC);
    vectors++; if (sel_hit !== 1'b1) begin miscompares++; $display("FAIL hit_base got %b want 1", sel_hit); end
    peek(16'hFFFF);
    vectors++; if (sel_hit !== 1'b1) begin miscompares++; $display("FAIL hit_top got %b want 1", sel_hit); end
  endtask

  task automatic test_bounds();
    cpu_write(16'hFFFD, 8'h07);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h91234) begin miscompares++; $display("FAIL last_legal got %h want %h", phys_addr, 20'h91234); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL last_legal_err got %b want 0", err); end
    cpu_write(16'hFFFD, 8'h08);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h91234) begin miscompares++; $display("FAIL first_illegal got %h want %h", phys_addr, 20'h91234); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL first_illegal_err got %b want 1", err); end
    cpu_write(16'hFFFD, 8'h0E);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h91234) begin miscompares++; $display("FAIL wrap_page got %h want %h", phys_addr, 20'h91234); end
    cpu_write(16'hFFFD, 8'h80);
    peek(16'h9234);
    vectors++; if (phys_addr !== 20'h29234) begin miscompares++; $display("FAIL win1_disk got %h want %h", phys_addr, 20'h29234); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", err); end
`ifdef BANK_MAPPER_READBACK_EN
    addr = 16'hFFFC; rd = 1'b1; tick(); rd = 1'b0;
    vectors++; if (dout !== 8'h89) begin miscompares++; $display("FAIL readback got %h want 89", dout); end
`endif
    cpu_write(16'hFFFC, 8'h80);
    peek(16'h9234);
    vectors++; if (phys_addr !== 20'h09234) begin miscompares++; $display("FAIL ofs_ram got %h want %h", phys_addr, 20'h09234); end
    en = 1'b0; cpu_write(16'hFFFE, 8'h00); en = 1'b1;
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h91234) begin miscompares++; $display("FAIL en_off got %h want %h", phys_addr, 20'h91234); end
    cpu_write(16'hFFFD, 8'h03);
  endtask

  task automatic test_load();
    load = 1'b1; tick();
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h01234) begin miscompares++; $display("FAIL load_clear got %h want %h", phys_addr, 20'h01234); end
    vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL load_state got %0d want 2", state_o); end
    cpu_write(16'hFFFE, 8'h00);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h01234) begin miscompares++; $display("FAIL load_ignore got %h want %h", phys_addr, 20'h01234); end
    load = 1'b0; tick();
    vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL load_exit got %0d want 1", state_o); end
    cpu_write(16'hFFFE, 8'h00);
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h11234) begin miscompares++; $display("FAIL rom_write got %h want %h", phys_addr, 20'h11234); end
    vectors++; if (rom_active !== 1'b1) begin miscompares++; $display("FAIL rom_active got %b want 1", rom_active); end
  endtask

  task automatic test_reset_mid_write();
    addr = 16'hFFFD; din = 8'h03; wr_n = 1'b0;
    #1;
    vectors++; if (page_o !== 4'd0) begin miscompares++; $display("FAIL pre_reset_page got %0d want 0", page_o); end
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    vectors++; if (page_o !== 4'd1) begin miscompares++; $display("FAIL async_page got %0d want 1", page_o); end
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL async_state got %0d want 0", state_o); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL no_edge_state got %0d want 0", state_o); end
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h11234) begin miscompares++; $display("FAIL no_edge_page got %h want %h", phys_addr, 20'h11234); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_clears_err got %b want 0", err); end
    wr_n = 1'b1; tick();
  endtask

  task automatic test_no_shadow();
    shadow_en = 1'b0;
    addr = 16'h8000; rd = 1'b1; tick(); rd = 1'b0;
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL noshadow_stay got %0d want 0", state_o); end
    cpu_write(16'hFFFF, 8'h00);
    vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL sel_exit got %0d want 1", state_o); end
    peek(16'h1234);
    vectors++; if (phys_addr !== 20'h11234) begin miscompares++; $display("FAIL exit_write_win0 got %h want %h", phys_addr, 20'h11234); end
    peek(16'h9234);
    vectors++; if (phys_addr !== 20'h09234) begin miscompares++; $display("FAIL exit_clear_win1 got %h want %h", phys_addr, 20'h09234); end
  endtask

  initial begin
    test_reset();
    test_shadow_exit();
    test_disk_write();
    test_bounds();
    test_load();
    test_reset_mid_write();
    test_no_shadow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
